// File: rtl/id_pkg.sv
// Shared constants for the ID stage.
// ALU op codes, RV32 field values and FSM encodings.
package id_pkg;

  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_JAL  = 5'b10000;
  localparam logic [4:0] ALU_BEQ  = 5'b10001;
  localparam logic [4:0] ALU_BLT  = 5'b10010;
  localparam logic [4:0] ALU_LW   = 5'b10100;
  localparam logic [4:0] ALU_SW   = 5'b10101;
  localparam logic [4:0] ALU_ADDI = 5'b01100;
  localparam logic [4:0] ALU_ADD  = 5'b01101;
  localparam logic [4:0] ALU_SUB  = 5'b01110;
  localparam logic [4:0] ALU_SLL  = 5'b01000;
  localparam logic [4:0] ALU_XOR  = 5'b00110;
  localparam logic [4:0] ALU_SRL  = 5'b01001;
  localparam logic [4:0] ALU_OR   = 5'b00101;
  localparam logic [4:0] ALU_AND  = 5'b00100;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BLT = 3'b100;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  typedef struct packed {
    logic [4:0] aluop;
    logic       wreg;
    logic       memrd;
    logic       memwr;
    logic       branch;
    logic       illegal;
    logic       use_rs1;
    logic       use_rs2;
  } id_ctrl_t;

  // Shared by R-type and I-type ALU forms; alt selects sub.
  function automatic logic [4:0] alu_of(
    input logic [2:0] f3,
    input logic       alt
  );
    case (f3)
      F3_ADD:  alu_of = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  alu_of = ALU_SLL;
      F3_XOR:  alu_of = ALU_XOR;
      F3_SRL:  alu_of = ALU_SRL;
      F3_OR:   alu_of = ALU_OR;
      F3_AND:  alu_of = ALU_AND;
      default: alu_of = ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/id_decode_comb.sv
// Pure combinational RV32-subset decoder.
// Produces control flags, operands and branch/link targets.
module id_decode_comb
  import id_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int EXT_IMM_OPS = 0
) (
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rdata1_i,
  input  logic [XLEN-1:0] rdata2_i,
  output id_ctrl_t        ctrl_o,
  output logic [XLEN-1:0] op1_o,
  output logic [XLEN-1:0] op2_o,
  output logic [XLEN-1:0] store_o,
  output logic [XLEN-1:0] baddr_o,
  output logic [XLEN-1:0] link_o
);

  localparam logic EXT = (EXT_IMM_OPS != 0);

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      r_alu;
  logic [4:0]      i_alu;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_j;

  logic d_jal, d_beq, d_blt, d_lw, d_sw;
  logic d_addi, d_iext, d_r;

  assign opc = inst_i[6:0];
  assign f3  = inst_i[14:12];
  assign f7  = inst_i[31:25];

  assign imm_i = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{(XLEN-12){inst_i[31]}},
                  inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{(XLEN-12){inst_i[31]}}, inst_i[7],
                  inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_j = {{(XLEN-20){inst_i[31]}}, inst_i[19:12],
                  inst_i[20], inst_i[30:21], 1'b0};

  assign r_alu = alu_of(f3, f7[5]);
  assign i_alu = alu_of(f3, 1'b0);

  assign d_jal  = (opc == OPC_JAL);
  assign d_beq  = (opc == OPC_BRANCH) & (f3 == F3_BEQ);
  assign d_blt  = (opc == OPC_BRANCH) & (f3 == F3_BLT);
  assign d_lw   = (opc == OPC_LOAD) & (f3 == F3_LW);
  assign d_sw   = (opc == OPC_STORE) & (f3 == F3_LW);
  assign d_addi = (opc == OPC_OPIMM) & (f3 == F3_ADD);
  assign d_iext = EXT & (opc == OPC_OPIMM) &
                  (f3 != F3_ADD) & (i_alu != ALU_NONE);
  // sub is the only alternate-funct7 form accepted
  assign d_r    = (opc == OPC_OP) & (r_alu != ALU_NONE) &
                  ((f7 == F7_BASE) |
                   ((f7 == F7_ALT) & (f3 == F3_ADD)));

  always_comb begin
    ctrl_o  = '0;
    op1_o   = rdata1_i;
    op2_o   = '0;
    store_o = '0;
    baddr_o = '0;
    link_o  = '0;
    unique case (1'b1)
      d_jal: begin
        ctrl_o.aluop  = ALU_JAL;
        ctrl_o.wreg   = 1'b1;
        ctrl_o.branch = 1'b1;
        op1_o         = '0;
        baddr_o       = pc_i + imm_j;
        link_o        = pc_i + XLEN'(4);
      end
      d_beq, d_blt: begin
        ctrl_o.aluop   = d_beq ? ALU_BEQ : ALU_BLT;
        ctrl_o.branch  = 1'b1;
        ctrl_o.use_rs1 = 1'b1;
        ctrl_o.use_rs2 = 1'b1;
        op2_o          = rdata2_i;
        baddr_o        = pc_i + imm_b;
      end
      d_lw: begin
        ctrl_o.aluop   = ALU_LW;
        ctrl_o.wreg    = 1'b1;
        ctrl_o.memrd   = 1'b1;
        ctrl_o.use_rs1 = 1'b1;
        op2_o          = imm_i;
      end
      d_sw: begin
        ctrl_o.aluop   = ALU_SW;
        ctrl_o.memwr   = 1'b1;
        ctrl_o.use_rs1 = 1'b1;
        ctrl_o.use_rs2 = 1'b1;
        op2_o          = imm_s;
        store_o        = rdata2_i;
      end
      d_addi, d_iext: begin
        ctrl_o.aluop   = d_addi ? ALU_ADDI : i_alu;
        ctrl_o.wreg    = 1'b1;
        ctrl_o.use_rs1 = 1'b1;
        op2_o          = imm_i;
      end
      d_r: begin
        ctrl_o.aluop   = r_alu;
        ctrl_o.wreg    = 1'b1;
        ctrl_o.use_rs1 = 1'b1;
        ctrl_o.use_rs2 = 1'b1;
        op2_o          = rdata2_i;
      end
      default: ctrl_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_stage_pipe.sv
// ID stage wrapper: decode, load-use stall FSM, flush
// handling and the registered ID/EX bundle.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int RA_W           = 5,
  parameter int LOAD_USE_STALL = 1,
  parameter int EXT_IMM_OPS    = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            id_valid_i,
  output logic            id_ready_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     inst_i,
  output logic [RA_W-1:0] raddr1_o,
  output logic [RA_W-1:0] raddr2_o,
  input  logic [XLEN-1:0] rdata1_i,
  input  logic [XLEN-1:0] rdata2_i,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [4:0]      ex_aluop_o,
  output logic [XLEN-1:0] ex_op1_o,
  output logic [XLEN-1:0] ex_op2_o,
  output logic [XLEN-1:0] ex_store_o,
  output logic [RA_W-1:0] ex_rd_o,
  output logic            ex_wreg_o,
  output logic            ex_memrd_o,
  output logic            ex_memwr_o,
  output logic            ex_branch_o,
  output logic [XLEN-1:0] ex_baddr_o,
  output logic [XLEN-1:0] ex_link_o,
  output logic            ex_illegal_o
);

  localparam logic [1:0] STALL_INIT = 2'(LOAD_USE_STALL - 1);

  id_ctrl_t        dc;
  logic [XLEN-1:0] d_op1, d_op2, d_store;
  logic [XLEN-1:0] d_baddr, d_link;
  logic [RA_W-1:0] rd;

  logic [0:0] state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       valid_q, valid_d;

  logic [4:0]      aluop_q;
  logic [XLEN-1:0] op1_q, op2_q, store_q;
  logic [RA_W-1:0] rd_q;
  logic            wreg_q, memrd_q, memwr_q;
  logic            branch_q, illegal_q;
  logic [XLEN-1:0] baddr_q, link_q;

  logic hazard, handoff, accept;

  id_decode_comb #(
    .XLEN        (XLEN),
    .EXT_IMM_OPS (EXT_IMM_OPS)
  ) u_dec (
    .inst_i   (inst_i),
    .pc_i     (pc_i),
    .rdata1_i (rdata1_i),
    .rdata2_i (rdata2_i),
    .ctrl_o   (dc),
    .op1_o    (d_op1),
    .op2_o    (d_op2),
    .store_o  (d_store),
    .baddr_o  (d_baddr),
    .link_o   (d_link)
  );

  assign raddr1_o = inst_i[15 +: RA_W];
  assign raddr2_o = inst_i[20 +: RA_W];
  assign rd       = inst_i[7 +: RA_W];

  assign hazard = valid_q & memrd_q & (rd_q != '0) &
                  id_valid_i &
                  ((dc.use_rs1 & (raddr1_o == rd_q)) |
                   (dc.use_rs2 & (raddr2_o == rd_q)));

  assign handoff    = ~valid_q | ex_ready_i;
  assign id_ready_o = ~rst & ~flush_i & (state_q == ST_RUN) &
                      ~hazard & handoff;
  assign accept     = id_valid_i & id_ready_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
      state_d = ST_RUN;
      cnt_d   = '0;
    end else if (state_q == ST_STALL) begin
      valid_d = 1'b0;
      cnt_d   = cnt_q - 2'd1;
      if (cnt_q == 2'd1) state_d = ST_RUN;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (hazard & ex_ready_i) begin
      // load handed off; the first bubble goes out now
      valid_d = 1'b0;
      cnt_d   = STALL_INIT;
      if (STALL_INIT != 2'd0) state_d = ST_STALL;
    end else if (ex_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aluop_q   <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      store_q   <= '0;
      rd_q      <= '0;
      wreg_q    <= 1'b0;
      memrd_q   <= 1'b0;
      memwr_q   <= 1'b0;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
      baddr_q   <= '0;
      link_q    <= '0;
    end else if (accept) begin
      aluop_q   <= dc.aluop;
      op1_q     <= d_op1;
      op2_q     <= d_op2;
      store_q   <= d_store;
      rd_q      <= rd;
      wreg_q    <= dc.wreg & (rd != '0);
      memrd_q   <= dc.memrd;
      memwr_q   <= dc.memwr;
      branch_q  <= dc.branch;
      illegal_q <= dc.illegal;
      baddr_q   <= d_baddr;
      link_q    <= d_link;
    end
  end

  assign ex_valid_o   = valid_q;
  assign ex_aluop_o   = aluop_q;
  assign ex_op1_o     = op1_q;
  assign ex_op2_o     = op2_q;
  assign ex_store_o   = store_q;
  assign ex_rd_o      = rd_q;
  assign ex_wreg_o    = wreg_q;
  assign ex_memrd_o   = memrd_q;
  assign ex_memwr_o   = memwr_q;
  assign ex_branch_o  = branch_q;
  assign ex_baddr_o   = baddr_q;
  assign ex_link_o    = link_q;
  assign ex_illegal_o = illegal_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: two instances (1 stall/base ops,
// 3 stalls/extended ops) against a transaction-level model.
module tb_id_stage_pipe;

  typedef struct packed {
    logic [4:0]  aluop;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] store;
    logic [4:0]  rd;
    logic        wreg;
    logic        memrd;
    logic        memwr;
    logic        branch;
    logic [31:0] baddr;
    logic [31:0] link;
    logic        illegal;
  } bund_t;

  logic        clk = 1'b0;
  logic        rst, flush, idv, exr;
  logic [31:0] pc, inst, rd1, rd2;

  logic        a_rdy, a_val, a_wreg, a_mrd, a_mwr, a_br, a_ill;
  logic [4:0]  a_ra1, a_ra2, a_alu, a_rd;
  logic [31:0] a_op1, a_op2, a_st, a_ba, a_lk;
  logic        b_rdy, b_val, b_wreg, b_mrd, b_mwr, b_br, b_ill;
  logic [4:0]  b_ra1, b_ra2, b_alu, b_rd;
  logic [31:0] b_op1, b_op2, b_st, b_ba, b_lk;

  bund_t obs_a, obs_b;
  assign obs_a = {a_alu, a_op1, a_op2, a_st, a_rd, a_wreg,
                  a_mrd, a_mwr, a_br, a_ba, a_lk, a_ill};
  assign obs_b = {b_alu, b_op1, b_op2, b_st, b_rd, b_wreg,
                  b_mrd, b_mwr, b_br, b_ba, b_lk, b_ill};

  int    n_assert = 0;
  int    n_fail   = 0;
  bit    m_v [2];
  bund_t m_b [2];
  int    m_stall [2];
  bit    rdy_seen [2];

  always #5 clk = ~clk;

  id_stage_pipe #(.LOAD_USE_STALL(1), .EXT_IMM_OPS(0)) dut_a (
    .clk(clk), .rst(rst), .flush_i(flush), .id_valid_i(idv),
    .id_ready_o(a_rdy), .pc_i(pc), .inst_i(inst),
    .raddr1_o(a_ra1), .raddr2_o(a_ra2),
    .rdata1_i(rd1), .rdata2_i(rd2),
    .ex_valid_o(a_val), .ex_ready_i(exr), .ex_aluop_o(a_alu),
    .ex_op1_o(a_op1), .ex_op2_o(a_op2), .ex_store_o(a_st),
    .ex_rd_o(a_rd), .ex_wreg_o(a_wreg), .ex_memrd_o(a_mrd),
    .ex_memwr_o(a_mwr), .ex_branch_o(a_br), .ex_baddr_o(a_ba),
    .ex_link_o(a_lk), .ex_illegal_o(a_ill)
  );

  id_stage_pipe #(.LOAD_USE_STALL(3), .EXT_IMM_OPS(1)) dut_b (
    .clk(clk), .rst(rst), .flush_i(flush), .id_valid_i(idv),
    .id_ready_o(b_rdy), .pc_i(pc), .inst_i(inst),
    .raddr1_o(b_ra1), .raddr2_o(b_ra2),
    .rdata1_i(rd1), .rdata2_i(rd2),
    .ex_valid_o(b_val), .ex_ready_i(exr), .ex_aluop_o(b_alu),
    .ex_op1_o(b_op1), .ex_op2_o(b_op2), .ex_store_o(b_st),
    .ex_rd_o(b_rd), .ex_wreg_o(b_wreg), .ex_memrd_o(b_mrd),
    .ex_memwr_o(b_mwr), .ex_branch_o(b_br), .ex_baddr_o(b_ba),
    .ex_link_o(b_lk), .ex_illegal_o(b_ill)
  );

  task automatic chk(input string tag,
                     input logic [199:0] o, input logic [199:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7,
    input logic [4:0] rs2, rs1, input logic [2:0] f3,
    input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(input logic [31:0] imm,
    input logic [4:0] rs1, input logic [2:0] f3,
    input logic [4:0] rd, input logic [6:0] opc);
    return {imm[11:0], rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm,
    input logic [4:0] rs2, rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm,
    input logic [4:0] rs2, rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11],
            7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm,
    input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [4:0] code_of(input string nm);
    case (nm)
      "addi":         return 5'b01100;
      "add":          return 5'b01101;
      "sub":          return 5'b01110;
      "sll", "slli":  return 5'b01000;
      "xor", "xori":  return 5'b00110;
      "srl", "srli":  return 5'b01001;
      "or", "ori":    return 5'b00101;
      "and", "andi":  return 5'b00100;
      default:        return 5'b00000;
    endcase
  endfunction

  // Reference decode: name the instruction, then apply its rule.
  function automatic void mdec(input logic [31:0] in, p, r1, r2,
    input bit ext, output bund_t b, output bit u1, output bit u2);
    logic [31:0] sg, iI, iS, iB, iJ;
    logic [2:0]  f3;
    logic [6:0]  f7;
    string       nm;
    f3 = in[14:12];
    f7 = in[31:25];
    sg = in[31] ? 32'hFFFF_FFFF : 32'h0;
    iI = (sg << 12) | 32'(in[31:20]);
    iS = (sg << 12) | (32'(in[31:25]) << 5) | 32'(in[11:7]);
    iB = (sg << 12) | (32'(in[7]) << 11) |
         (32'(in[30:25]) << 5) | (32'(in[11:8]) << 1);
    iJ = (sg << 20) | (32'(in[19:12]) << 12) |
         (32'(in[20]) << 11) | (32'(in[30:21]) << 1);
    nm = "bad";
    case (in[6:0])
      7'h6F: nm = "jal";
      7'h63: if (f3 == 0) nm = "beq"; else if (f3 == 4) nm = "blt";
      7'h03: if (f3 == 2) nm = "lw";
      7'h23: if (f3 == 2) nm = "sw";
      7'h13: case (f3)
        3'd0: nm = "addi";
        3'd1: if (ext) nm = "slli";
        3'd4: if (ext) nm = "xori";
        3'd5: if (ext) nm = "srli";
        3'd6: if (ext) nm = "ori";
        3'd7: if (ext) nm = "andi";
        default: ;
      endcase
      7'h33: if (f7 == 0) case (f3)
        3'd0: nm = "add";
        3'd1: nm = "sll";
        3'd4: nm = "xor";
        3'd5: nm = "srl";
        3'd6: nm = "or";
        3'd7: nm = "and";
        default: ;
      endcase else if (f7 == 7'h20 && f3 == 0) nm = "sub";
      default: ;
    endcase
    b = '0; u1 = 0; u2 = 0;
    b.rd = in[11:7];
    b.op1 = r1;
    case (nm)
      "jal": begin
        b.aluop = 5'b10000; b.op1 = 0; b.wreg = 1; b.branch = 1;
        b.baddr = p + iJ; b.link = p + 4;
      end
      "beq", "blt": begin
        b.aluop = (nm == "beq") ? 5'b10001 : 5'b10010;
        b.op2 = r2; b.branch = 1; b.baddr = p + iB; u1 = 1; u2 = 1;
      end
      "lw": begin
        b.aluop = 5'b10100; b.op2 = iI; b.memrd = 1; b.wreg = 1;
        u1 = 1;
      end
      "sw": begin
        b.aluop = 5'b10101; b.op2 = iS; b.store = r2; b.memwr = 1;
        u1 = 1; u2 = 1;
      end
      "add", "sub", "sll", "xor", "srl", "or", "and": begin
        b.aluop = code_of(nm); b.op2 = r2; b.wreg = 1;
        u1 = 1; u2 = 1;
      end
      "bad": b.illegal = 1;
      default: begin
        b.aluop = code_of(nm); b.op2 = iI; b.wreg = 1; u1 = 1;
      end
    endcase
    if (b.rd == 0) b.wreg = 0;
  endfunction

  // One clock: check both instances, advance the model.
  task automatic tick();
    bund_t d, ob, nb [2];
    bit    u1, u2, hz, er, nv [2];
    int    ns [2];
    #2;
    chk("raddr1", {a_ra1, b_ra1}, {inst[19:15], inst[19:15]});
    chk("raddr2", {a_ra2, b_ra2}, {inst[24:20], inst[24:20]});
    for (int k = 0; k < 2; k++) begin
      mdec(inst, pc, rd1, rd2, k == 1, d, u1, u2);
      hz = m_v[k] && m_b[k].memrd && m_b[k].rd != 0 && idv &&
           ((u1 && inst[19:15] == m_b[k].rd) ||
            (u2 && inst[24:20] == m_b[k].rd));
      er = !rst && !flush && m_stall[k] == 0 && !hz &&
           (!m_v[k] || exr);
      ob = (k == 0) ? obs_a : obs_b;
      rdy_seen[k] = (k == 0) ? a_rdy : b_rdy;
      chk($sformatf("id_ready[%0d]", k), rdy_seen[k], er);
      chk($sformatf("ex_valid[%0d]", k),
          (k == 0) ? a_val : b_val, m_v[k]);
      if (m_v[k]) chk($sformatf("bundle[%0d]", k), ob, m_b[k]);
      nv[k] = m_v[k]; nb[k] = m_b[k]; ns[k] = m_stall[k];
      if (rst) begin
        nv[k] = 0; nb[k] = '0; ns[k] = 0;
      end else if (flush) begin
        nv[k] = 0; ns[k] = 0;
      end else if (m_stall[k] > 0) begin
        nv[k] = 0; ns[k] = m_stall[k] - 1;
      end else if (idv && er) begin
        nv[k] = 1; nb[k] = d;
      end else if (hz && exr) begin
        nv[k] = 0; ns[k] = (k == 0) ? 0 : 2;
      end else if (exr) begin
        nv[k] = 0;
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_v[k] = nv[k]; m_b[k] = nb[k]; m_stall[k] = ns[k];
    end
    @(negedge clk);
  endtask

  task automatic drv(input bit v, input logic [31:0] i,
                     input logic [31:0] p);
    idv = v; inst = i; pc = p;
    rd1 = $urandom; rd2 = $urandom;
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [4:0]  rd, r1, r2;
    logic [31:0] imm;
    logic [2:0]  f3;
    rd  = 5'($urandom_range(0, 7));
    r1  = 5'($urandom_range(0, 7));
    r2  = 5'($urandom_range(0, 7));
    imm = $urandom;
    case ($urandom_range(0, 5))
      0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b100;
      3: f3 = 3'b101; 4: f3 = 3'b110; default: f3 = 3'b111;
    endcase
    case ($urandom_range(0, 11))
      0:  return enc_j(imm, rd);
      1:  return enc_b(imm, r2, r1, 3'b000);
      2:  return enc_b(imm, r2, r1, 3'b100);
      3:  return enc_b(imm, r2, r1, 3'($urandom_range(5, 7)));
      4, 5: return enc_i(imm, r1, 3'b010, rd, 7'b0000011);
      6:  return enc_s(imm, r2, r1);
      7:  return enc_i(imm, r1, 3'b000, rd, 7'b0010011);
      8:  return enc_r((f3 == 0 && imm[0]) ? 7'h20 : 7'h00,
                      r2, r1, f3, rd, 7'b0110011);
      9:  return enc_i(imm, r1, f3, rd, 7'b0010011);
      10: return enc_r(7'h01, r2, r1, f3, rd, 7'b0110011);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int za, zb;
    bit da, db;
    rst = 1; flush = 0; exr = 1;
    drv(0, 32'h0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      m_v[k] = 0; m_b[k] = '0; m_stall[k] = 0;
    end
    @(negedge clk);

    // reset held two cycles
    tick(); tick();
    chk("rst_bundle_a", obs_a, '0);
    chk("rst_bundle_b", obs_b, '0);
    chk("rst_valid", {a_val, b_val}, 2'b00);
    rst = 0;
    tick();
    chk("post_rst_ready", {rdy_seen[0], rdy_seen[1]}, 2'b11);

    // addi x1,x0,5 then add x3,x1,x2
    drv(1, enc_i(5, 0, 3'b000, 1, 7'b0010011), 32'h0);
    tick();
    chk("addi_aluop", a_alu, 5'b01100);
    chk("addi_op2", a_op2, 32'd5);
    drv(1, enc_r(0, 2, 1, 3'b000, 3, 7'b0110011), 32'h4);
    tick();
    chk("add_aluop", a_alu, 5'b01101);
    chk("add_wreg", {a_val, a_wreg}, 2'b11);
    drv(0, 32'h0, 32'h8);
    tick();

    // lw x5,0(x1) then dependent add x6,x5,x2
    drv(1, enc_i(0, 1, 3'b010, 5, 7'b0000011), 32'h10);
    tick();
    drv(1, enc_r(0, 2, 5, 3'b000, 6, 7'b0110011), 32'h14);
    za = 0; zb = 0; da = 0; db = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (!da) begin if (rdy_seen[0]) da = 1; else za++; end
      if (!db) begin if (rdy_seen[1]) db = 1; else zb++; end
    end
    chk("lu_bubbles_1", za, 1);
    chk("lu_bubbles_3", zb, 3);
    drv(0, 32'h0, 32'h18);
    tick(); tick();

    // EX back-pressure holding sub
    drv(1, enc_r(7'h20, 2, 1, 3'b000, 7, 7'b0110011), 32'h20);
    tick();
    drv(1, enc_i(3, 1, 3'b000, 8, 7'b0010011), 32'h24);
    exr = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_sub", {a_alu, a_val, rdy_seen[0]}, {5'b01110, 2'b10});
    end
    exr = 1;
    tick();
    chk("release_addi", {a_alu, a_val}, {5'b01100, 1'b1});

    // jal and an illegal branch funct3
    drv(1, enc_j(32'h20, 1), 32'h100);
    tick();
    chk("jal_baddr", a_ba, 32'h120);
    chk("jal_link", a_lk, 32'h104);
    chk("jal_branch", a_br, 1'b1);
    drv(1, enc_b(32'h8, 2, 1, 3'b001), 32'h104);
    tick();
    chk("beq_f3_illegal", {a_ill, a_br}, 2'b10);

    // flush while instance b sits in STALL
    drv(1, enc_i(0, 1, 3'b010, 5, 7'b0000011), 32'h200);
    tick();
    drv(1, enc_r(0, 2, 5, 3'b000, 6, 7'b0110011), 32'h204);
    tick();
    flush = 1;
    tick();
    flush = 0;
    chk("flush_valid", {a_val, b_val}, 2'b00);
    drv(0, 32'h0, 32'h208);
    tick();
    chk("flush_run_ready", rdy_seen[1], 1'b1);
    chk("flush_no_take", b_val, 1'b0);

    // reset abandons a stall
    drv(1, enc_i(0, 1, 3'b010, 5, 7'b0000011), 32'h300);
    tick();
    drv(1, enc_r(0, 2, 5, 3'b000, 6, 7'b0110011), 32'h304);
    tick();
    rst = 1;
    tick();
    rst = 0;
    drv(0, 32'h0, 32'h308);
    tick();
    chk("rst_stall_ready", rdy_seen[1], 1'b1);

    // andi x4,x1,7 with and without extended ops
    drv(1, enc_i(7, 1, 3'b111, 4, 7'b0010011), 32'h400);
    tick();
    chk("andi_base", {a_ill, a_alu}, {1'b1, 5'b00000});
    chk("andi_ext", {b_ill, b_alu}, {1'b0, 5'b00100});

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 19) == 0);
      exr   = ($urandom_range(0, 9) < 7);
      drv($urandom_range(0, 3) != 0, rnd_inst(),
          $urandom & 32'hFFFF_FFFC);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
